// File: rtl/dwa_thermo_decoder.sv
// Registered binary-to-thermometer decoder for the DCO unit-cell bank, with
// optional data-weighted-averaging rotation of the enabled cell window.
module dwa_thermo_decoder #(
  parameter int BIN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [BIN_W-1:0]        bin,
  input  logic                    mode,
  output logic [(1<<BIN_W)-1:0]   thermo,
  output logic                    out_valid,
  output logic [BIN_W-1:0]        ptr
);

  localparam int N = 1 << BIN_W;

  logic [N-1:0]     mask;
  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [N-1:0]     thermo_next;
  logic [BIN_W-1:0] ptr_next;

  // NOTE: every always_comb output gets a value on every path (defaults first),
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    mask        = '0;
    dbl         = '0;
    rot         = '0;
    thermo_next = '0;
    ptr_next    = '0;

    // bin never exceeds N-1, so the mask never reaches all-ones.
    mask = (N'(1) << bin) - N'(1);

    // Rotate-left by ptr: bits pushed past the top wrap back to cell 0.
    dbl = {{N{1'b0}}, mask} << ptr;
    rot = dbl[N-1:0] | dbl[2*N-1:N];

    if (mode) begin
      thermo_next = rot;
      ptr_next    = ptr + bin;
    end else begin
      thermo_next = mask;
      ptr_next    = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      thermo    <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        thermo <= thermo_next;
        ptr    <= ptr_next;
      end
    end
  end

endmodule

// File: doc/dwa_thermo_decoder.md
# dwa_thermo_decoder

Parametrised, registered binary-to-thermometer decoder with optional data-weighted-averaging (DWA) rotation for driving the FLB DCO unit-cell array. It is the sequential successor of the combinational 4-to-16 B2T decoder. It generalises the code width. Its rotating start pointer spreads unit-cell usage to first-order shape cell-mismatch error. It sits between the loop-filter integer word and the DCO cell bank, one register stage ahead of the cells.

## Interface
- BIN_W, default 4: binary code width; cell count N = 2**BIN_W (localparam).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  qualifies bin/mode for the current cycle.
- bin  in  BIN_W  number of cells to enable, k = 0..N-1.
- mode  in  1  0 = plain thermometer, 1 = DWA rotation.
- thermo  out  N  registered cell-enable vector.
- out_valid  out  1  high for one cycle after each accepted in_valid.
- ptr  out  BIN_W  current DWA start pointer (debug/observability).

## Operation
- Reset values, held while rst=1: thermo = 0, out_valid = 0, ptr = 0.
- An input is accepted on a rising edge when in_valid=1 and rst=0.
- Plain mode (mode=0), on accept:
  - thermo[i] = 1 for i < k, else 0.
  - ptr is cleared to 0, so every entry into DWA starts at cell 0.
- DWA mode (mode=1), on accept:
  - thermo[i] = 1 for the k cells ptr, ptr+1, …, ptr+k-1, all modulo N; all other bits are 0.
  - ptr_next = (ptr + k) mod N; the carry out of BIN_W bits is discarded.
- k = 0 in either mode: thermo becomes all zeros. In DWA mode ptr is unchanged.
- popcount(thermo) = k always; at most N-1 ones; all-ones is never produced.
- in_valid = 0: thermo and ptr hold their previous values; out_valid = 0.
- mode is sampled only with in_valid; mode changes while in_valid=0 have no effect.
- Pointer arithmetic is BIN_W-bit unsigned with natural wrap.
- rst asserted mid-stream overrides any accept in the same cycle and forces all reset values.

## Timing
- Latency is 1 cycle. bin is sampled at edge t with in_valid=1; thermo, ptr and out_valid=1 are visible after edge t.
- Back-to-back accepts are supported every cycle; throughput is 1 code/cycle.
- The ptr output shows the pointer that the next DWA accept will use.
- thermo changes only on an accept edge or a reset edge; it is glitch-free by construction since it is a pure register output.
- No combinational path from any input to any output.

## Test plan
- Reset: drive rst=1 for 2 cycles with in_valid=1 and bin=4'hF. Required: thermo=0, out_valid=0 and ptr=0 throughout; first accept after release yields out_valid one cycle later.
- Plain sweep (BIN_W=4, mode=0): apply bin 0..15 on consecutive cycles. Required:
  - thermo = (1<<k)-1 one cycle after each code, e.g. bin=5 gives 16'h001F and bin=15 gives 16'h7FFF.
  - ptr stays 0.
- DWA sequence (mode=1, starting from ptr=0): apply bin 3, 5, 0, 4. Required:
  - thermo = 16'h0007, 16'h00F8, 16'h0000, 16'h0F00.
  - ptr = 3, 8, 8, 12.
- DWA wrap: with ptr=14, apply bin=5. Required: thermo = 16'hC007 (bits 14, 15, 0, 1, 2); ptr = 3.
- Hold and mode switch:
  - Hold: after a DWA accept, drop in_valid for 3 cycles while toggling bin and mode. Required: thermo and ptr unchanged, out_valid=0.
  - Mode switch: then apply mode=0, bin=2, followed by mode=1, bin=2. Required: 16'h0003 with ptr=0, then 16'h0003 with ptr=2.
- Randomised back-to-back with mid-stream reset: drive random bin/mode/in_valid for 1000 cycles against a reference model. Required: popcount(thermo)=k on every out_valid. Also assert rst for one cycle mid-stream; the next DWA output must start at cell 0.
